mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even and >= 4.
REQ-002 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  in  1  request; sampled only in IDLE.
REQ-005 SHALL have port Function_opcode  in  6  operation: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
REQ-006 SHALL have port Read_data_1  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source).
REQ-007 SHALL have port Read_data_2  in  WIDTH  rt operand (multiplier / divisor).
REQ-008 SHALL have port Flush  in  1  abort of an in-flight operation.
REQ-009 SHALL have port Busy  out  1  high while state != IDLE.
REQ-010 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port Div_zero  out  1  sticky-until-next-Start flag for div/divu with Read_data_2 == 0.
REQ-012 SHALL have ports HI_result, LO_result  out  WIDTH  architectural HI/LO registers.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; transitions IDLE->CALC on accepted mul/div Start, CALC->FIX after exactly WIDTH CALC cycles, FIX->IDLE unconditionally.
REQ-014 SHALL latch operands and opcode at the accepting edge (E0); later input changes SHALL NOT affect the result.
REQ-015 SHALL use an iterative one-bit-per-cycle shift-add multiplier and restoring divider on operand magnitudes, with sign correction applied in FIX.
REQ-016 SHALL write HI/LO at edge E0+WIDTH+1 (FIX->IDLE) and assert Done during the following cycle only; Busy high from after E0 until that edge.
REQ-017 SHALL produce mult/multu as {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
REQ-018 SHALL produce div/divu as LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-019 SHALL for divisor 0 keep full latency, set LO = all ones, HI = Read_data_1, and Div_zero = 1 with Done.
REQ-020 SHALL for signed div of most-negative by -1 give LO = most-negative, HI = 0, Div_zero = 0.
REQ-021 SHALL execute mthi/mtlo in one cycle from IDLE: write HI or LO with Read_data_1 at E0, Done high next cycle, Busy stays 0, other register unchanged.
REQ-022 SHALL ignore Start while Busy; SHALL ignore Start with an unlisted opcode (no state change, no Done).
REQ-023 SHALL on Flush in CALC or FIX return to IDLE at the next edge with HI/LO unchanged and no Done; Flush SHALL have priority over completion in FIX; Flush in IDLE SHALL be ignored and SHALL NOT block a same-cycle Start.
REQ-024 SHALL clear Div_zero when a new Start is accepted.
REQ-025 SHALL keep HI/LO stable between completions.

Reset
REQ-026 SHALL on reset_n low, asynchronously and at any point including mid-operation: state IDLE, cycle counter 0, HI_result = LO_result = 0, Busy = Done = Div_zero = 0.
REQ-027 SHALL accept Start on the first rising edge after reset_n deasserts.

Verification (WIDTH=32)
REQ-028 SHALL verify multu 0xFFFFFFFF x 0xFFFFFFFF -> HI 0xFFFFFFFE, LO 0x00000001, Done exactly one cycle, 34 cycles after E0, Busy high for 33 cycles.
REQ-029 SHALL verify mult -3 x 5 -> HI 0xFFFFFFFF, LO 0xFFFFFFF1; div -7 / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF.
REQ-030 SHALL verify divu 7 / 0 -> LO 0xFFFFFFFF, HI 0x00000007, Div_zero 1; div 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-031 SHALL verify Start (divu 9/2) issued 5 cycles into a running mult is ignored: only the mult result lands, single Done.
REQ-032 SHALL verify Flush at CALC cycle 10 and reset_n low at CALC cycle 20 (separate runs) -> IDLE, no Done, HI/LO respectively unchanged and zero.
REQ-033 SHALL verify mthi 0x12345678 then mtlo 0x9ABCDEF0 back-to-back -> HI 0x12345678, LO 0x9ABCDEF0, Busy never high, two Done pulses.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Ports
//   clock, reset_n       : single rising-edge clock, asynchronous active-low reset
//   Start                : operation request, only looked at while idle
//   Function_opcode[5:0] : mult 011000, multu 011001, div 011010, divu 011011,
//                          mthi 010001, mtlo 010011 (anything else is ignored)
//   Read_data_1/2        : rs / rt operands, captured on the accepting edge
//   Flush                : abandons an operation in CALC or FIX (no HI/LO write)
//   Busy                 : high while a multiply/divide is in flight
//   Done                 : one-cycle pulse after HI/LO have been written
//   Div_zero             : set with Done for a zero divisor, cleared on next accept
//   HI_result, LO_result : architectural HI/LO registers
//   state_dbg            : current FSM state (IDLE=0, CALC=1, FIX=2)
//
// Handshake: a request is accepted on a rising edge where the unit is idle,
// Start is high and the opcode is listed; there is no ready back-pressure,
// requests arriving while Busy are dropped. Done is the only completion signal.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [5:0]       Function_opcode,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             Div_zero,
  output logic [WIDTH-1:0] HI_result,
  output logic [WIDTH-1:0] LO_result,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mag_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_mul_q, a_neg_q, b_neg_q, dz_pend_q;
  logic             done_q, div_zero_q;

  // Request decode
  logic             op_mul, op_div, op_signed;
  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;

  assign op_mul    = (Function_opcode == OP_MULT) || (Function_opcode == OP_MULTU);
  assign op_div    = (Function_opcode == OP_DIV)  || (Function_opcode == OP_DIVU);
  assign op_signed = (Function_opcode == OP_MULT) || (Function_opcode == OP_DIV);
  assign in_a_neg  = op_signed & Read_data_1[WIDTH-1];
  assign in_b_neg  = op_signed & Read_data_2[WIDTH-1];
  assign in_a_mag  = in_a_neg ? -Read_data_1 : Read_data_1;
  assign in_b_mag  = in_b_neg ? -Read_data_2 : Read_data_2;

  // One iteration. Multiply: {acc_hi,acc_lo} starts as {0, multiplier} and
  // shifts right, adding the multiplicand into the top half when the LSB is 1.
  // Divide: acc_lo starts as the dividend and shifts left into the partial
  // remainder in acc_hi while quotient bits enter at the bottom of acc_lo.
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_q};
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (is_mul_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      step_hi = div_trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction. With a zero divisor the remainder path just shifts the
  // dividend magnitude into acc_hi, so re-applying the dividend sign restores
  // the original rs value; only the quotient needs forcing to all ones.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    if (is_mul_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = a_neg_q ? -acc_hi : acc_hi;
      fix_lo = dz_pend_q ? '1 : ((a_neg_q ^ b_neg_q) ? -acc_lo : acc_lo);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      mag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_mul_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && (op_mul || op_div)) begin
            state      <= ST_CALC;
            cnt        <= '0;
            is_mul_q   <= op_mul;
            a_neg_q    <= in_a_neg;
            b_neg_q    <= in_b_neg;
            acc_hi     <= '0;
            acc_lo     <= op_mul ? in_b_mag : in_a_mag;
            mag_q      <= op_mul ? in_a_mag : in_b_mag;
            dz_pend_q  <= op_div && (Read_data_2 == '0);
            div_zero_q <= 1'b0;
          end else if (Start && (Function_opcode == OP_MTHI)) begin
            hi_q       <= Read_data_1;
            done_q     <= 1'b1;
            div_zero_q <= 1'b0;
          end else if (Start && (Function_opcode == OP_MTLO)) begin
            lo_q       <= Read_data_1;
            done_q     <= 1'b1;
            div_zero_q <= 1'b0;
          end
        end
        ST_CALC: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          // A flush landing on the final cycle still wins over completion.
          if (!Flush) begin
            hi_q       <= fix_hi;
            lo_q       <= fix_lo;
            done_q     <= 1'b1;
            div_zero_q <= dz_pend_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state != ST_IDLE);
  assign Done      = done_q;
  assign Div_zero  = div_zero_q;
  assign HI_result = hi_q;
  assign LO_result = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit (WIDTH=32).
// A monitor pops an expected {Div_zero,HI,LO} from exp_q on every Done pulse;
// expectations come from a plain-arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [5:0]   Function_opcode = '0;
  logic [W-1:0] Read_data_1 = '0;
  logic [W-1:0] Read_data_2 = '0;
  logic         Flush = 1'b0;
  logic         Busy, Done, Div_zero;
  logic [W-1:0] HI_result, LO_result;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;

  always #5 clock = ~clock;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .Start(Start),
    .Function_opcode(Function_opcode), .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2), .Flush(Flush), .Busy(Busy), .Done(Done),
    .Div_zero(Div_zero), .HI_result(HI_result), .LO_result(LO_result),
    .state_dbg(state_dbg)
  );

  // Reference model: returns {div_zero, hi, lo} after the operation.
  function automatic logic [2*W:0] ref_result(input logic [5:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] cur_hi,
                                              input logic [W-1:0] cur_lo);
    longint       sa, sb;
    logic [63:0]  p;
    logic [W-1:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      OP_DIV: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {1'b0, r, q};
      end
      OP_DIVU: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
      OP_MTHI: return {1'b0, a, cur_lo};
      OP_MTLO: return {1'b0, cur_hi, a};
      default: return {1'b0, cur_hi, cur_lo};
    endcase
  endfunction

  task automatic expect_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W:0] e;
    e = ref_result(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    m_hi = e[2*W-1:W];
    m_lo = e[W-1:0];
  endtask

  // Scoreboard monitor
  always @(posedge clock) begin
    #1;
    if (reset_n === 1'b1 && Done === 1'b1) begin
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: Done=1 with nothing outstanding (hi=%h lo=%h)", HI_result, LO_result);
      end else begin
        mon_e = exp_q.pop_front();
        if ({Div_zero, HI_result, LO_result} !== mon_e) begin
          errors++;
          $display("FAIL result: got dz=%b hi=%h lo=%h, want dz=%b hi=%h lo=%h",
                   Div_zero, HI_result, LO_result, mon_e[2*W], mon_e[2*W-1:W], mon_e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push);
    Start = 1'b1;
    Function_opcode = op;
    Read_data_1 = a;
    Read_data_2 = b;
    if (push) expect_op(op, a, b);
    tick;
    // Scramble inputs after the accepting edge: the result must not follow them.
    Start = 1'b0;
    Function_opcode = 6'($urandom_range(63, 0));
    Read_data_1 = $urandom;
    Read_data_2 = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      if (Busy === 1'b1) busy_n++;
      if (Done === 1'b1) seen = 1'b1;
      else begin tick; lat++; end
    end
  endtask

  task automatic run_md(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, busy_n;
    bit seen;
    start_op(op, a, b, 1'b1);
    wait_done(lat, busy_n, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL md_timeout: op=%b no Done within %0d cycles", op, lat);
    end else begin
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL md_latency: op=%b Done %0d edges after accept, want %0d", op, lat, W + 1);
      end
      checks++;
      if (busy_n != W + 1) begin
        errors++;
        $display("FAIL md_busy_cycles: op=%b Busy high %0d cycles, want %0d", op, busy_n, W + 1);
      end
      tick;
      checks++;
      if (Done !== 1'b0) begin
        errors++;
        $display("FAIL md_done_width: Done=%b one cycle after pulse, want 0", Done);
      end
    end
  endtask

  task automatic check_hilo(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
    checks++;
    if (HI_result !== hi || LO_result !== lo) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name, HI_result, LO_result, hi, lo);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({Busy, Done, Div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dz=%b, want 000", {Busy, Done, Div_zero});
    end
    check_hilo("reset_hilo", '0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    // First edge after release must accept.
    start_op(OP_MTHI, 32'hA5A5_0001, '0, 1'b1);
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL first_start: Done=%b after first edge, want 1", Done);
    end
    tick;
  endtask

  task automatic test_directed;
    int lat, busy_n;
    bit seen;
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    run_md(OP_MULT, -32'sd3, 32'd5);
    check_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md(OP_DIV, -32'sd7, 32'd2);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md(OP_DIVU, 32'd7, 32'd0);
    check_hilo("divu_zero", 32'h0000_0007, 32'hFFFF_FFFF);
    repeat (3) tick;
    checks++;
    if (Div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_sticky: Div_zero=%b while idle after div by zero, want 1", Div_zero);
    end
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (Div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear: Div_zero=%b after new accept, want 0", Div_zero);
    end
    wait_done(lat, busy_n, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL div_ovf_timeout: no Done within %0d cycles", lat);
    end
    tick;
    check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_back_to_back_mt;
    int d;
    bit busy_hi;
    d = 0; busy_hi = 1'b0;
    start_op(OP_MTHI, 32'h1234_5678, '0, 1'b1);
    if (Busy !== 1'b0) busy_hi = 1'b1;
    if (Done === 1'b1) d++;
    start_op(OP_MTLO, 32'h9ABC_DEF0, '0, 1'b1);
    if (Busy !== 1'b0) busy_hi = 1'b1;
    if (Done === 1'b1) d++;
    tick;
    if (Busy !== 1'b0) busy_hi = 1'b1;
    if (Done === 1'b1) d++;
    checks++;
    if (busy_hi) begin
      errors++;
      $display("FAIL mt_busy: Busy went high during mthi/mtlo, want 0");
    end
    checks++;
    if (d != 2) begin
      errors++;
      $display("FAIL mt_done_count: %0d Done cycles, want 2", d);
    end
    check_hilo("mt_b2b", 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  task automatic test_ignore_start;
    int d0;
    d0 = done_seen;
    start_op(OP_MULT, $urandom, $urandom, 1'b1);
    repeat (4) tick;
    Start = 1'b1; Function_opcode = OP_DIVU; Read_data_1 = 32'd9; Read_data_2 = 32'd2;
    tick;
    Start = 1'b0;
    repeat (60) tick;
    checks++;
    if (done_seen - d0 != 1) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d Done pulses, want 1", done_seen - d0);
    end
    check_hilo("busy_start_result", m_hi, m_lo);
  endtask

  task automatic test_bad_opcode;
    logic [5:0] bad [5] = '{6'b000000, 6'b011100, 6'b010000, 6'b010010, 6'b111111};
    for (int i = 0; i < 5; i++) begin
      start_op(bad[i], $urandom, $urandom, 1'b0);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
        errors++;
        $display("FAIL bad_opcode: op=%b busy=%b done=%b, want 0 0", bad[i], Busy, Done);
      end
    end
    tick;
    check_hilo("bad_opcode_hilo", m_hi, m_lo);
  endtask

  task automatic test_flush;
    int d0, lat, busy_n;
    bit seen;
    // Flush at CALC cycle 10
    d0 = done_seen;
    start_op(OP_DIVU, $urandom, 32'd3, 1'b0);
    repeat (9) tick;
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc_idle: Busy=%b after flush, want 0", Busy);
    end
    repeat (40) tick;
    checks++;
    if (done_seen != d0) begin
      errors++;
      $display("FAIL flush_calc_done: %0d Done pulses, want 0", done_seen - d0);
    end
    check_hilo("flush_calc_hilo", m_hi, m_lo);
    // Flush on the FIX cycle beats completion
    d0 = done_seen;
    start_op(OP_MULTU, 32'hFFFF_0000, 32'h0001_0003, 1'b0);
    repeat (W) tick;
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_fix_busy: Busy=%b in final cycle, want 1", Busy);
    end
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    repeat (5) tick;
    checks++;
    if (Busy !== 1'b0 || done_seen != d0) begin
      errors++;
      $display("FAIL flush_fix: busy=%b done pulses=%0d, want 0 0", Busy, done_seen - d0);
    end
    check_hilo("flush_fix_hilo", m_hi, m_lo);
    // Flush while idle must not block a same-cycle Start
    Flush = 1'b1;
    start_op(OP_MTLO, 32'hCAFE_F00D, '0, 1'b1);
    Flush = 1'b0;
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_mt: Done=%b, want 1", Done);
    end
    Flush = 1'b1;
    start_op(OP_MULTU, 32'd1000, 32'd1000, 1'b1);
    Flush = 1'b0;
    wait_done(lat, busy_n, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_idle_md: no Done within %0d cycles", lat);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int d0;
    start_op(OP_MTHI, 32'hDEAD_BEEF, '0, 1'b1);
    start_op(OP_MTLO, 32'h0BAD_F00D, '0, 1'b1);
    tick;
    start_op(OP_DIVU, $urandom, 32'd5, 1'b0);
    repeat (19) tick;
    #2;
    reset_n = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    checks++;
    if ({Busy, Done, Div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_flags: busy/done/dz=%b, want 000", {Busy, Done, Div_zero});
    end
    check_hilo("reset_mid_hilo", '0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = done_seen;
    repeat (40) tick;
    checks++;
    if (done_seen != d0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: done pulses=%0d busy=%b, want 0 0", done_seen - d0, Busy);
    end
  endtask

  task automatic test_random;
    logic [5:0]   ops [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    logic [5:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(5, 0)];
      case ($urandom_range(4, 0))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(5, 0))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(7, 1));
        default: b = $urandom;
      endcase
      if (op == OP_MTHI || op == OP_MTLO) begin
        start_op(op, a, b, 1'b1);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_mt: op=%b done=%b busy=%b, want 1 0", op, Done, Busy);
        end
      end else begin
        run_md(op, a, b);
      end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back_mt;
    test_ignore_start;
    test_bad_opcode;
    test_flush;
    test_reset_mid;
    test_random;
    repeat (3) tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected results never completed, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
